// File: rtl/uart_pkg.sv
// uart_pkg: types and defaults shared by the UART receiver, transmitter and tick generator.
package uart_pkg;
   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} uart_rx_state_t;
   localparam int UART_DEFAULT_SAMPLE_RATE = 16;
   localparam int UART_DEFAULT_DATA_BITS = 8;
endpackage

// File: rtl/uart_rx_if.sv
// uart_rx_if: serial input, oversample strobe and frame result signals of the UART receiver.
interface uart_rx_if import uart_pkg::*; #(
   parameter int DATA_BITS = UART_DEFAULT_DATA_BITS
);
   logic                 tick_in;
   logic                 rx_in;
   logic [DATA_BITS-1:0] data_out;
   logic                 valid_out;
   logic                 frame_err_out;
   logic                 parity_err_out;
   logic                 busy_out;
   modport slave (
      input  tick_in, rx_in,
      output data_out, valid_out, frame_err_out, parity_err_out, busy_out
   );
   modport master (
      output tick_in, rx_in,
      input  data_out, valid_out, frame_err_out, parity_err_out, busy_out
   );
endinterface

// File: rtl/uart_rx_sync.sv
// uart_rx_sync: two-flop synchroniser for an asynchronous input, with a configurable reset value.
module uart_rx_sync #(
   parameter logic RST_VAL = 1'b1
) (
   input  logic clk_in,
   input  logic rst_n_in,
   input  logic d_in,
   output logic q_out
);
   logic meta_q, meta_d, sync_q, sync_d;
   always_comb begin
      meta_d = d_in;
      sync_d = meta_q;
   end
   always_ff @(posedge clk_in) begin
      if (!rst_n_in) begin
         meta_q <= RST_VAL;
         sync_q <= RST_VAL;
      end else begin
         meta_q <= meta_d;
         sync_q <= sync_d;
      end
   end
   assign q_out = sync_q;
endmodule

// File: rtl/uart_rx.sv
// uart_rx: oversampling UART receiver; start qualified at mid-bit, data sampled at bit centre, LSB first.
// Define UART_RX_PARITY_EN to expect an even-parity bit between the data and stop bits.
module uart_rx import uart_pkg::*; #(
   parameter int SAMPLE_RATE = UART_DEFAULT_SAMPLE_RATE,
   parameter int DATA_BITS = UART_DEFAULT_DATA_BITS
) (
   input logic      clk_in,
   input logic      rst_n_in,
   uart_rx_if.slave bus
);
   localparam int CW = $clog2(SAMPLE_RATE);
   localparam int BW = $clog2(DATA_BITS);
   localparam logic [CW-1:0] CNT_MID = CW'(SAMPLE_RATE / 2 - 1);
   localparam logic [CW-1:0] CNT_END = CW'(SAMPLE_RATE - 1);
   localparam logic [BW-1:0] IDX_END = BW'(DATA_BITS - 1);
`ifdef UART_RX_PARITY_EN
   localparam uart_rx_state_t AFTER_DATA = PARITY;
`else
   localparam uart_rx_state_t AFTER_DATA = STOP;
`endif

   uart_rx_state_t       state_q, state_d;
   logic [CW-1:0]        cnt_q, cnt_d;
   logic [BW-1:0]        idx_q, idx_d;
   logic [DATA_BITS-1:0] shreg_q, shreg_d, data_q, data_d;
   logic                 par_bad_q, par_bad_d;
   logic                 valid_q, valid_d, ferr_q, ferr_d, perr_q, perr_d, busy_q, busy_d;
   logic                 rx_s, at_end;

   uart_rx_sync #(.RST_VAL(1'b1)) u_sync (
      .clk_in   (clk_in),
      .rst_n_in (rst_n_in),
      .d_in     (bus.rx_in),
      .q_out    (rx_s)
   );

   assign at_end = cnt_q == CNT_END;

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      idx_d     = idx_q;
      shreg_d   = shreg_q;
      par_bad_d = par_bad_q;
      data_d    = data_q;
      valid_d   = 1'b0;
      ferr_d    = 1'b0;
      perr_d    = 1'b0;
      if (bus.tick_in) begin
         case (state_q)
            IDLE: begin
               state_d = rx_s ? IDLE : START;
               cnt_d   = '0;
            end
            START: begin
               cnt_d = (cnt_q == CNT_MID) ? '0 : cnt_q + 1'b1;
               if (cnt_q == CNT_MID) begin
                  state_d = rx_s ? IDLE : DATA;
                  idx_d   = '0;
               end
            end
            DATA: begin
               cnt_d = at_end ? '0 : cnt_q + 1'b1;
               if (at_end) begin
                  shreg_d = {rx_s, shreg_q[DATA_BITS-1:1]};
                  state_d = (idx_q == IDX_END) ? AFTER_DATA : DATA;
                  idx_d   = (idx_q == IDX_END) ? idx_q : idx_q + 1'b1;
               end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
               cnt_d = at_end ? '0 : cnt_q + 1'b1;
               if (at_end) begin
                  par_bad_d = rx_s ^ (^shreg_q);
                  state_d   = STOP;
               end
            end
`endif
            STOP: begin
               cnt_d = at_end ? '0 : cnt_q + 1'b1;
               if (at_end) begin
                  state_d = IDLE;
                  ferr_d  = !rx_s;
                  perr_d  = rx_s && par_bad_q;
                  valid_d = rx_s && !par_bad_q;
                  data_d  = (rx_s && !par_bad_q) ? shreg_q : data_q;
               end
            end
            default: begin
               state_d = IDLE;
               cnt_d   = '0;
            end
         endcase
      end
      busy_d = state_d != IDLE;
   end

   always_ff @(posedge clk_in) begin
      if (!rst_n_in) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         idx_q     <= '0;
         shreg_q   <= '0;
         par_bad_q <= 1'b0;
         data_q    <= '0;
         valid_q   <= 1'b0;
         ferr_q    <= 1'b0;
         perr_q    <= 1'b0;
         busy_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         idx_q     <= idx_d;
         shreg_q   <= shreg_d;
         par_bad_q <= par_bad_d;
         data_q    <= data_d;
         valid_q   <= valid_d;
         ferr_q    <= ferr_d;
         perr_q    <= perr_d;
         busy_q    <= busy_d;
      end
   end

   assign bus.data_out       = data_q;
   assign bus.valid_out      = valid_q;
   assign bus.frame_err_out  = ferr_q;
   assign bus.parity_err_out = perr_q;
   assign bus.busy_out       = busy_q;
endmodule
